// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// MEM-stage data-memory access controller. It sits between EX/MEM and MEM/WB.
// A load or store leaves EX/MEM as a req/ack transaction on the data-memory
// port. The pipeline is stalled until that transaction completes. A load's
// result is returned aligned and extended on mem_mo.
//
// Ports:
//   clk            pipeline clock, rising edge
//   clr            asynchronous active-high reset
//   mem_rmem       load in MEM stage
//   mem_wmem       store in MEM stage (wins if both are set)
//   mem_size       00 byte, 01 half, 10 word, 11 illegal
//   mem_unsigned   zero-extend sub-word loads
//   mem_alu_result effective byte address
//   mem_store_data store source value
//   dmem_req       bus request, high for every ACCESS cycle
//   dmem_we        bus write
//   dmem_addr      word address (low two bits zero)
//   dmem_wdata     lane-replicated store data
//   dmem_be        byte enables, bit i = byte i
//   dmem_ack       one-cycle bus completion
//   dmem_rdata     read word, valid with dmem_ack
//   mem_mo         formatted load result for MEM/WB
//   mem_stall      freezes the front of the pipeline
//   misalign       one-cycle alignment / illegal-size flag
//   bus_err        one-cycle timeout flag, raised in DONE

module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mem_rmem,
    input  logic        mem_wmem,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_mo,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic              access;
    logic              bad;
    logic              start;
    logic [CNT_W-1:0]  count;
    logic [1:0]        lo_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              store_q;
    logic [31:0]       mo_q;
    logic              err_q;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;
    logic [31:0]       load_fmt;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign access = mem_rmem | mem_wmem;

    // Alignment check: size 11 is never legal regardless of address.
    always_comb begin
        bad = 1'b0;
        case (mem_size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = mem_alu_result[0];
            2'b10:   bad = |mem_alu_result[1:0];
            default: bad = 1'b1;
        endcase
    end

    assign start = (state == IDLE) && access && !bad;

    // Byte-lane enables and replicated store data for the access being issued.
    always_comb begin
        be_next    = 4'b0000;
        wdata_next = 32'h0;
        case (mem_size)
            2'b00: begin
                be_next    = 4'b0001 << mem_alu_result[1:0];
                wdata_next = {4{mem_store_data[7:0]}};
            end
            2'b01: begin
                be_next    = mem_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{mem_store_data[15:0]}};
            end
            2'b10: begin
                be_next    = 4'b1111;
                wdata_next = mem_store_data;
            end
            default: begin
                be_next    = 4'b0000;
                wdata_next = 32'h0;
            end
        endcase
    end

    // Load formatting uses the address/size captured at issue, so it does not
    // depend on EX/MEM staying frozen while the bus is busy.
    always_comb begin
        byte_sel = 8'h0;
        case (lo_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_fmt = dmem_rdata;
        case (size_q)
            2'b00:   load_fmt = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_fmt = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. DONE always returns to IDLE, so the instruction still
    // sitting in EX/MEM during DONE is never issued a second time.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCESS;
            ACCESS:  if (dmem_ack || (count == LAST_CNT)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs. The stall and misalign terms are masked by clr so the pipeline
    // sees no stall while reset is being applied.
    always_comb begin
        dmem_req  = (state == ACCESS);
        mem_stall = !clr && (start || (state == ACCESS));
        misalign  = !clr && (state == IDLE) && access && bad;
        mem_mo    = misalign ? 32'h0 : mo_q;
        bus_err   = err_q;
    end

    // Bus registers, timeout counter and result capture.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'b0000;
            count      <= '0;
            lo_q       <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            store_q    <= 1'b0;
            mo_q       <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_we    <= mem_wmem;
                        dmem_addr  <= {mem_alu_result[31:2], 2'b00};
                        dmem_wdata <= mem_wmem ? wdata_next : 32'h0;
                        dmem_be    <= be_next;
                        count      <= '0;
                        lo_q       <= mem_alu_result[1:0];
                        size_q     <= mem_size;
                        uns_q      <= mem_unsigned;
                        store_q    <= mem_wmem;
                    end else if (access) begin
                        mo_q <= 32'h0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        mo_q <= store_q ? 32'h0 : load_fmt;
                    end else if (count == LAST_CNT) begin
                        mo_q  <= 32'h0;
                        err_q <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//
// Directed bench for mem_access_unit with a short timeout (TIMEOUT=4) so the
// bus-error path is reached quickly. Each test task drives one scenario and
// compares outputs against hand-computed values.

module tb_mem_access_unit;

    logic        clk;
    logic        clr;
    logic        mem_rmem;
    logic        mem_wmem;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_mo;
    logic        mem_stall;
    logic        misalign;
    logic        bus_err;

    int errors;
    int checks;

    mem_access_unit #(
        .TIMEOUT(4),
        .CNT_W  (3)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .mem_rmem      (mem_rmem),
        .mem_wmem      (mem_wmem),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .mem_mo        (mem_mo),
        .mem_stall     (mem_stall),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sd);
        mem_rmem       = rd;
        mem_wmem       = wr;
        mem_size       = sz;
        mem_unsigned   = uns;
        mem_alu_result = addr;
        mem_store_data = sd;
    endtask

    task automatic drive_none();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // Runs one legal access whose inputs are already driven in the request
    // cycle. Acks on ACCESS cycle ack_at (0 = never). Returns in DONE with
    // the bus values seen in the first ACCESS cycle.
    task automatic run_access(input int ack_at, input logic [31:0] rdata,
                              output int stall_cycles, output int acc_cycles,
                              output logic finished, output logic we_s,
                              output logic [31:0] addr_s, output logic [31:0] wdata_s,
                              output logic [3:0] be_s);
        stall_cycles = 0;
        acc_cycles   = 0;
        finished     = 1'b0;
        we_s         = 1'b0;
        addr_s       = 32'h0;
        wdata_s      = 32'h0;
        be_s         = 4'h0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (mem_stall) begin
                stall_cycles++;
            end else if (i > 0) begin
                finished = 1'b1;
                break;
            end
            if (dmem_req) begin
                acc_cycles++;
                if (acc_cycles == 1) begin
                    we_s    = dmem_we;
                    addr_s  = dmem_addr;
                    wdata_s = dmem_wdata;
                    be_s    = dmem_be;
                end
                if (acc_cycles == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        drive_none();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #12;
        checks++;
        if ({dmem_req, dmem_we, dmem_be, mem_stall, misalign, bus_err} !== 9'h0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {dmem_req, dmem_we, dmem_be, mem_stall, misalign, bus_err});
        end
        checks++;
        if ({dmem_addr, dmem_wdata, mem_mo} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr %h wdata %h mo %h expected 0", dmem_addr, dmem_wdata, mem_mo);
        end
        @(negedge clk);
        clr = 1'b0;
        tick();
        checks++;
        if ({mem_stall, dmem_req} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_idle: got stall %b req %b expected 0 0", mem_stall, dmem_req);
        end
    endtask

    task automatic test_load_word();
        int st, ac;
        logic fin, we_s;
        logic [31:0] a_s, w_s;
        logic [3:0] b_s;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        run_access(3, 32'hDEADBEEF, st, ac, fin, we_s, a_s, w_s, b_s);
        checks++;
        if (!fin) begin
            errors++;
            $display("[TB] FAIL lw_done: access did not finish within bound");
        end
        checks++;
        if (a_s !== 32'h100 || b_s !== 4'b1111 || we_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_bus: got addr %h be %b we %b expected 00000100 1111 0", a_s, b_s, we_s);
        end
        checks++;
        if (st !== 4 || ac !== 3) begin
            errors++;
            $display("[TB] FAIL lw_latency: got stall %0d access %0d expected 4 3", st, ac);
        end
        checks++;
        if (mem_mo !== 32'hDEADBEEF || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_done_out: got mo %h stall %b req %b expected deadbeef 0 0", mem_mo, mem_stall, dmem_req);
        end
        drive_none();
        tick();
        checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_no_reissue: got req %b stall %b expected 0 0", dmem_req, mem_stall);
        end
    endtask

    task automatic test_load_format();
        int st, ac;
        logic fin, we_s;
        logic [31:0] a_s, w_s;
        logic [3:0] b_s;
        logic [31:0] exp_mo [3];
        logic        uns    [3];
        logic [1:0]  sz     [3];
        logic [31:0] adr    [3];
        exp_mo = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012};
        uns    = '{1'b0, 1'b1, 1'b0};
        sz     = '{2'b00, 2'b00, 2'b01};
        adr    = '{32'h103, 32'h103, 32'h102};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, sz[k], uns[k], adr[k], 32'h0);
            run_access(1, 32'h80123456, st, ac, fin, we_s, a_s, w_s, b_s);
            checks++;
            if (!fin || mem_mo !== exp_mo[k] || st !== 2) begin
                errors++;
                $display("[TB] FAIL load_fmt%0d: got mo %h stall %0d done %b expected %h 2 1", k, mem_mo, st, fin, exp_mo[k]);
            end
            drive_none();
            tick();
        end
        checks++;
        if (b_s !== 4'b1100 || a_s !== 32'h100) begin
            errors++;
            $display("[TB] FAIL lh_bus: got be %b addr %h expected 1100 00000100", b_s, a_s);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h11111111;
        tick();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if (mem_mo !== 32'hFFFF8012 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got mo %h req %b stall %b expected ffff8012 0 0", mem_mo, dmem_req, mem_stall);
        end
    endtask

    task automatic test_misalign();
        logic req_seen;
        req_seen = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        #1;
        checks++;
        if (misalign !== 1'b1 || mem_stall !== 1'b0 || mem_mo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mis_word: got mis %b stall %b mo %h expected 1 0 0", misalign, mem_stall, mem_mo);
        end
        tick();
        req_seen = req_seen | dmem_req;
        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (misalign !== 1'b1 || mem_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mis_size: got mis %b stall %b expected 1 0", misalign, mem_stall);
        end
        tick();
        req_seen = req_seen | dmem_req;
        drive_none();
        #1;
        checks++;
        if (misalign !== 1'b0 || req_seen !== 1'b0 || mem_mo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mis_clear: got mis %b req_seen %b mo %h expected 0 0 0", misalign, req_seen, mem_mo);
        end
    endtask

    task automatic test_store();
        int st, ac;
        logic fin, we_s;
        logic [31:0] a_s, w_s;
        logic [3:0] b_s;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        run_access(1, 32'h5555AAAA, st, ac, fin, we_s, a_s, w_s, b_s);
        drive_none();
        tick();
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD);
        run_access(2, 32'h99999999, st, ac, fin, we_s, a_s, w_s, b_s);
        checks++;
        if (we_s !== 1'b1 || b_s !== 4'b1100 || w_s !== 32'hABCDABCD || a_s !== 32'h100) begin
            errors++;
            $display("[TB] FAIL sh_bus: got we %b be %b wdata %h addr %h expected 1 1100 abcdabcd 00000100", we_s, b_s, w_s, a_s);
        end
        checks++;
        if (!fin || mem_mo !== 32'h0 || st !== 3) begin
            errors++;
            $display("[TB] FAIL sh_done: got mo %h stall %0d done %b expected 0 3 1", mem_mo, st, fin);
        end
        drive_none();
        tick();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000EE);
        run_access(1, 32'h77777777, st, ac, fin, we_s, a_s, w_s, b_s);
        checks++;
        if (we_s !== 1'b1 || b_s !== 4'b0010 || w_s !== 32'hEEEEEEEE || mem_mo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL sb_both: got we %b be %b wdata %h mo %h expected 1 0010 eeeeeeee 0", we_s, b_s, w_s, mem_mo);
        end
        drive_none();
        tick();
    endtask

    task automatic test_timeout();
        int st, ac;
        logic fin, we_s;
        logic [31:0] a_s, w_s;
        logic [3:0] b_s;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        run_access(1, 32'h5555AAAA, st, ac, fin, we_s, a_s, w_s, b_s);
        checks++;
        if (mem_mo !== 32'h5555AAAA || bus_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_timeout: got mo %h err %b expected 5555aaaa 0", mem_mo, bus_err);
        end
        drive_none();
        tick();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        run_access(0, 32'h0, st, ac, fin, we_s, a_s, w_s, b_s);
        checks++;
        if (!fin || ac !== 4 || st !== 5) begin
            errors++;
            $display("[TB] FAIL to_len: got access %0d stall %0d done %b expected 4 5 1", ac, st, fin);
        end
        checks++;
        if (bus_err !== 1'b1 || mem_mo !== 32'h0 || dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_done: got err %b mo %h req %b expected 1 0 0", bus_err, mem_mo, dmem_req);
        end
        drive_none();
        tick();
        checks++;
        if (bus_err !== 1'b0 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_idle: got err %b stall %b req %b expected 0 0 0", bus_err, mem_stall, dmem_req);
        end
    endtask

    task automatic test_clear_mid_access();
        int st, ac;
        logic fin, we_s;
        logic [31:0] a_s, w_s;
        logic [3:0] b_s;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        tick();
        tick();
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h200) begin
            errors++;
            $display("[TB] FAIL clr_pre: got req %b addr %h expected 1 00000200", dmem_req, dmem_addr);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_be, mem_stall, misalign, bus_err} !== 9'h0 ||
            {dmem_addr, dmem_wdata, mem_mo} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL clr_now: got req %b stall %b addr %h be %b mo %h expected all 0", dmem_req, mem_stall, dmem_addr, dmem_be, mem_mo);
        end
        clr = 1'b0;
        drive_none();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mem_mo !== 32'h0 || mem_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_ack_ignored: got req %b mo %h stall %b expected 0 0 0", dmem_req, mem_mo, mem_stall);
        end
        tick();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        run_access(2, 32'h12345678, st, ac, fin, we_s, a_s, w_s, b_s);
        checks++;
        if (!fin || mem_mo !== 32'h12345678 || st !== 3 || a_s !== 32'h300) begin
            errors++;
            $display("[TB] FAIL clr_recover: got mo %h stall %0d addr %h done %b expected 12345678 3 00000300 1", mem_mo, st, a_s, fin);
        end
        drive_none();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_load_word();
        test_load_format();
        test_misalign();
        test_store();
        test_timeout();
        test_clear_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
